// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue-stage RAW hazard scoreboard:
// result classes, slot layout and the class-decode helper.
package issue_scoreboard_pkg;

    typedef enum logic [1:0] {
        SB_CLS_ALU  = 2'd0,
        SB_CLS_LOAD = 2'd1,
        SB_CLS_MUL  = 2'd2,
        SB_CLS_LONG = 2'd3
    } sb_cls_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        sb_cls_e    cls;
    } sb_slot_t;

    localparam int unsigned SB_SLOT_W = 8;

    localparam sb_slot_t SB_SLOT_EMPTY = '{valid: 1'b0, rd: 5'd0, cls: SB_CLS_ALU};

    // lsu > mul > div/csr > ALU
    function automatic sb_cls_e sb_classify(input logic lsu, input logic mul,
                                            input logic div, input logic csr);
        if (lsu)
            return SB_CLS_LOAD;
        else if (mul)
            return SB_CLS_MUL;
        else if (div || csr)
            return SB_CLS_LONG;
        else
            return SB_CLS_ALU;
    endfunction

endpackage

// File: rtl/issue_scoreboard_src_check.sv
// sb_src_check: hazard decision for one source operand against the E1 and E2
// slots. The WB slot is always forwarded, so it never contributes a hazard.
module sb_src_check
    import issue_scoreboard_pkg::*;
#(
    parameter bit SUPPORT_LOAD_BYPASS = 1'b1,
    parameter bit SUPPORT_MUL_BYPASS  = 1'b1
) (
    input  logic [4:0] i_src,
    input  logic       i_used,
    input  sb_slot_t   i_e1,
    input  sb_slot_t   i_e2,
    output logic       o_hazard
);

    logic w_live;
    logic w_e1_hit;
    logic w_e2_hit;

    assign w_live   = i_used && (i_src != 5'd0);
    assign w_e1_hit = w_live && i_e1.valid && (i_e1.rd == i_src);
    assign w_e2_hit = w_live && i_e2.valid && (i_e2.rd == i_src);

    // Youngest matching slot decides: an E1 hit shadows any E2 hit.
    always_comb begin
        o_hazard = 1'b0;
        if (w_e1_hit) begin
            o_hazard = (i_e1.cls != SB_CLS_ALU);
        end else if (w_e2_hit) begin
            case (i_e2.cls)
                SB_CLS_LOAD: o_hazard = !SUPPORT_LOAD_BYPASS;
                SB_CLS_MUL:  o_hazard = !SUPPORT_MUL_BYPASS;
                default:     o_hazard = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: shadows destination/class of instructions in E1, E2 and WB
// and stalls issue on a RAW hazard that cannot yet be forwarded.
// Optional macro SCOREBOARD_PERF_EN builds a saturating hazard-stall counter.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter bit SUPPORT_LOAD_BYPASS = 1'b1,
    parameter bit SUPPORT_MUL_BYPASS  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    input  logic        issue_accept_i,
    input  logic        issue_stall_i,
    input  logic        issue_rd_valid_i,
    input  logic [4:0]  issue_rd_i,
    input  logic [4:0]  issue_ra_i,
    input  logic [4:0]  issue_rb_i,
    input  logic        issue_ra_used_i,
    input  logic        issue_rb_used_i,
    input  logic        issue_lsu_i,
    input  logic        issue_mul_i,
    input  logic        issue_div_i,
    input  logic        issue_csr_i,
    input  logic        squash_e1_e2_i,
    input  logic        squash_wb_i,
    output logic        hazard_stall_o,
    output logic        hazard_ra_o,
    output logic        hazard_rb_o,
    output logic [31:0] pending_mask_o,
    output logic [31:0] stall_count_o
);

    sb_slot_t    r_e1;
    sb_slot_t    r_e2;
    sb_slot_t    r_wb;
    sb_slot_t    w_new;
    logic        w_ra_hz;
    logic        w_rb_hz;
    logic [31:0] w_mask;

    // Build the E1 entry for an instruction accepted this cycle.
    always_comb begin
        w_new = SB_SLOT_EMPTY;
        if (issue_valid_i && issue_accept_i && !squash_e1_e2_i) begin
            w_new.valid = 1'b1;
            w_new.rd    = (issue_rd_valid_i && (issue_rd_i != 5'd0)) ? issue_rd_i : 5'd0;
            w_new.cls   = sb_classify(issue_lsu_i, issue_mul_i, issue_div_i, issue_csr_i);
        end
    end

    // Advance the slots; a global stall holds everything, including over squashes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_e1 <= SB_SLOT_EMPTY;
            r_e2 <= SB_SLOT_EMPTY;
            r_wb <= SB_SLOT_EMPTY;
        end else if (!issue_stall_i) begin
            r_wb <= squash_wb_i    ? SB_SLOT_EMPTY : r_e2;
            r_e2 <= squash_e1_e2_i ? SB_SLOT_EMPTY : r_e1;
            r_e1 <= w_new;
        end
    end

    sb_src_check #(
        .SUPPORT_LOAD_BYPASS (SUPPORT_LOAD_BYPASS),
        .SUPPORT_MUL_BYPASS  (SUPPORT_MUL_BYPASS)
    ) u_chk_ra (
        .i_src    (issue_ra_i),
        .i_used   (issue_ra_used_i),
        .i_e1     (r_e1),
        .i_e2     (r_e2),
        .o_hazard (w_ra_hz)
    );

    sb_src_check #(
        .SUPPORT_LOAD_BYPASS (SUPPORT_LOAD_BYPASS),
        .SUPPORT_MUL_BYPASS  (SUPPORT_MUL_BYPASS)
    ) u_chk_rb (
        .i_src    (issue_rb_i),
        .i_used   (issue_rb_used_i),
        .i_e1     (r_e1),
        .i_e2     (r_e2),
        .o_hazard (w_rb_hz)
    );

    assign hazard_ra_o    = issue_valid_i && w_ra_hz;
    assign hazard_rb_o    = issue_valid_i && w_rb_hz;
    assign hazard_stall_o = hazard_ra_o || hazard_rb_o;

    // OR of one-hot(rd) over valid slots; x0 never reported.
    always_comb begin
        w_mask = '0;
        if (r_e1.valid) w_mask[r_e1.rd] = 1'b1;
        if (r_e2.valid) w_mask[r_e2.rd] = 1'b1;
        if (r_wb.valid) w_mask[r_wb.rd] = 1'b1;
        w_mask[0] = 1'b0;
    end

    assign pending_mask_o = w_mask;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] r_stall_count;

    // Count effective hazard stalls, saturating at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_stall_count <= '0;
        else if (hazard_stall_o && !issue_stall_i && (r_stall_count != '1))
            r_stall_count <= r_stall_count + 32'd1;
    end

    assign stall_count_o = r_stall_count;
`else
    assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard. Two instances share one stimulus stream:
// u_dut_a with both bypasses enabled, u_dut_b with both disabled.
module tb_issue_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i, issue_accept_i, issue_stall_i, issue_rd_valid_i;
    logic [4:0]  issue_rd_i, issue_ra_i, issue_rb_i;
    logic        issue_ra_used_i, issue_rb_used_i;
    logic        issue_lsu_i, issue_mul_i, issue_div_i, issue_csr_i;
    logic        squash_e1_e2_i, squash_wb_i;

    logic        a_stall, a_ra, a_rb, b_stall, b_ra, b_rb;
    logic [31:0] a_mask, a_cnt, b_mask, b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    issue_scoreboard u_dut_a (
        .clk_i (clk_i), .rst_i (rst_i),
        .issue_valid_i (issue_valid_i), .issue_accept_i (issue_accept_i),
        .issue_stall_i (issue_stall_i), .issue_rd_valid_i (issue_rd_valid_i),
        .issue_rd_i (issue_rd_i), .issue_ra_i (issue_ra_i), .issue_rb_i (issue_rb_i),
        .issue_ra_used_i (issue_ra_used_i), .issue_rb_used_i (issue_rb_used_i),
        .issue_lsu_i (issue_lsu_i), .issue_mul_i (issue_mul_i),
        .issue_div_i (issue_div_i), .issue_csr_i (issue_csr_i),
        .squash_e1_e2_i (squash_e1_e2_i), .squash_wb_i (squash_wb_i),
        .hazard_stall_o (a_stall), .hazard_ra_o (a_ra), .hazard_rb_o (a_rb),
        .pending_mask_o (a_mask), .stall_count_o (a_cnt)
    );

    issue_scoreboard #(
        .SUPPORT_LOAD_BYPASS (1'b0),
        .SUPPORT_MUL_BYPASS  (1'b0)
    ) u_dut_b (
        .clk_i (clk_i), .rst_i (rst_i),
        .issue_valid_i (issue_valid_i), .issue_accept_i (issue_accept_i),
        .issue_stall_i (issue_stall_i), .issue_rd_valid_i (issue_rd_valid_i),
        .issue_rd_i (issue_rd_i), .issue_ra_i (issue_ra_i), .issue_rb_i (issue_rb_i),
        .issue_ra_used_i (issue_ra_used_i), .issue_rb_used_i (issue_rb_used_i),
        .issue_lsu_i (issue_lsu_i), .issue_mul_i (issue_mul_i),
        .issue_div_i (issue_div_i), .issue_csr_i (issue_csr_i),
        .squash_e1_e2_i (squash_e1_e2_i), .squash_wb_i (squash_wb_i),
        .hazard_stall_o (b_stall), .hazard_ra_o (b_ra), .hazard_rb_o (b_rb),
        .pending_mask_o (b_mask), .stall_count_o (b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid_i    = 1'b0; issue_accept_i  = 1'b0; issue_rd_valid_i = 1'b0;
        issue_rd_i       = 5'd0; issue_ra_i      = 5'd0; issue_rb_i       = 5'd0;
        issue_ra_used_i  = 1'b0; issue_rb_used_i = 1'b0;
        issue_lsu_i      = 1'b0; issue_mul_i     = 1'b0; issue_div_i      = 1'b0;
        issue_csr_i      = 1'b0;
    endtask

    // Present one instruction: rd, ra, rb, used flags, class flags {lsu,mul,div,csr}.
    task automatic op(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                      input logic rau, input logic rbu, input logic [3:0] cls);
        issue_valid_i    = 1'b1; issue_rd_valid_i = 1'b1; issue_rd_i = rd;
        issue_ra_i       = ra;   issue_rb_i       = rb;
        issue_ra_used_i  = rau;  issue_rb_used_i  = rbu;
        {issue_lsu_i, issue_mul_i, issue_div_i, issue_csr_i} = cls;
    endtask

    task automatic drain();
        idle();
        repeat (3) @(negedge clk_i);
    endtask

    localparam logic [3:0] C_ALU = 4'b0000, C_LSU = 4'b1000, C_MUL = 4'b0100, C_DIV = 4'b0010;

    initial begin
        rst_i = 1'b1; issue_stall_i = 1'b0; squash_e1_e2_i = 1'b0; squash_wb_i = 1'b0;
        idle();
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_stall", a_stall, 0); check("rst_ra", a_ra, 0); check("rst_rb", a_rb, 0);
        check("rst_mask", a_mask, 0);   check("rst_cnt", a_cnt, 0); check("rst_mask_b", b_mask, 0);
        @(negedge clk_i); rst_i = 1'b0;

        // Test 1: load x5 then add reading x5; accept follows dut_a
        @(negedge clk_i); op(5, 0, 0, 0, 0, C_LSU); issue_accept_i = 1'b1;
        #1 check("t1_load_nostall", a_stall, 0);
        @(negedge clk_i); op(6, 5, 0, 1, 0, C_ALU); issue_accept_i = 1'b0;
        #1 check("t1_c1_stall_a", a_stall, 1); check("t1_c1_ra_a", a_ra, 1);
        check("t1_c1_rb_a", a_rb, 0); check("t1_c1_mask", a_mask, 32'h20);
        check("t1_c1_stall_b", b_stall, 1);
        @(negedge clk_i);
        #1 check("t1_c2_stall_a", a_stall, 0); check("t1_c2_stall_b", b_stall, 1);
        issue_accept_i = 1'b1;
        @(negedge clk_i); idle();
        #1 check("t1_mask_after", a_mask, 32'h60);
        drain();

        // Test 2: same sequence, accept follows dut_b (no load bypass)
        @(negedge clk_i); op(5, 0, 0, 0, 0, C_LSU); issue_accept_i = 1'b1;
        @(negedge clk_i); op(6, 5, 0, 1, 0, C_ALU); issue_accept_i = 1'b0;
        #1 check("t2_c1_stall_b", b_stall, 1); check("t2_c1_mask", b_mask, 32'h20);
        @(negedge clk_i);
        #1 check("t2_c2_stall_b", b_stall, 1); check("t2_c2_mask", b_mask, 32'h20);
        @(negedge clk_i);
        #1 check("t2_c3_stall_b", b_stall, 0); check("t2_c3_mask", b_mask, 32'h20);
        issue_accept_i = 1'b1;
        @(negedge clk_i); idle();
        #1 check("t2_mask_after", b_mask, 32'h40);
        drain();
`ifdef SCOREBOARD_PERF_EN
        check("perf_cnt_a", a_cnt, 2); check("perf_cnt_b", b_cnt, 4);
`else
        check("perf_cnt_a", a_cnt, 0); check("perf_cnt_b", b_cnt, 0);
`endif

        // Test 3: div x7 held in E1 by a 10-cycle global stall
        @(negedge clk_i); op(7, 0, 0, 0, 0, C_DIV); issue_accept_i = 1'b1;
        @(negedge clk_i); op(8, 0, 7, 0, 1, C_ALU); issue_accept_i = 1'b0; issue_stall_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1 check("t3_hold_stall", a_stall, 1); check("t3_hold_rb", a_rb, 1);
            check("t3_hold_mask", a_mask, 32'h80);
            @(negedge clk_i);
        end
        issue_stall_i = 1'b0;
        #1 check("t3_release_stall", a_stall, 1);
        @(negedge clk_i);
        #1 check("t3_clear_a", a_stall, 0); check("t3_clear_b", b_stall, 0);
        issue_accept_i = 1'b1;
        drain();

        // Test 4: mul x3 squashed out of E1
        @(negedge clk_i); op(3, 0, 0, 0, 0, C_MUL); issue_accept_i = 1'b1;
        @(negedge clk_i); idle(); squash_e1_e2_i = 1'b1;
        #1 check("t4_mask_pre", a_mask, 32'h08);
        @(negedge clk_i); squash_e1_e2_i = 1'b0; op(4, 3, 0, 1, 0, C_ALU);
        #1 check("t4_mask_post", a_mask, 0); check("t4_stall_a", a_stall, 0);
        check("t4_stall_b", b_stall, 0);
        issue_accept_i = 1'b1;
        drain();

        // Squash and global stall together: stall wins; then mul bypass difference
        @(negedge clk_i); op(3, 0, 0, 0, 0, C_MUL); issue_accept_i = 1'b1;
        @(negedge clk_i); idle(); squash_e1_e2_i = 1'b1; squash_wb_i = 1'b1; issue_stall_i = 1'b1;
        @(negedge clk_i); squash_e1_e2_i = 1'b0; squash_wb_i = 1'b0; issue_stall_i = 1'b0;
        op(4, 3, 0, 1, 0, C_ALU);
        #1 check("sqst_mask", a_mask, 32'h08); check("sqst_stall_a", a_stall, 1);
        @(negedge clk_i);
        #1 check("mul_e2_a", a_stall, 0); check("mul_e2_b", b_stall, 1);
        issue_accept_i = 1'b1;
        drain();

        // Test 5: E1=ALU x9 shadows E2=LOAD x9
        @(negedge clk_i); op(9, 0, 0, 0, 0, C_LSU); issue_accept_i = 1'b1;
        @(negedge clk_i); op(9, 0, 0, 0, 0, C_ALU);
        #1 check("t5_alu_issue_b", b_stall, 0);
        @(negedge clk_i); op(10, 9, 0, 1, 0, C_ALU);
        #1 check("t5_stall_b", b_stall, 0); check("t5_stall_a", a_stall, 0);
        check("t5_mask", b_mask, 32'h200);
        drain();

        // Test 6: load to x0 then reader of x0
        @(negedge clk_i); op(0, 0, 0, 0, 0, C_LSU); issue_accept_i = 1'b1;
        @(negedge clk_i); op(11, 0, 0, 1, 1, C_ALU);
        #1 check("t6_stall_a", a_stall, 0); check("t6_stall_b", b_stall, 0);
        check("t6_mask", a_mask, 0);
        drain();

        // ra==rb both flagged, then reset mid-stall
        @(negedge clk_i); op(5, 0, 0, 0, 0, C_LSU); issue_accept_i = 1'b1;
        @(negedge clk_i); op(6, 5, 5, 1, 1, C_ALU); issue_accept_i = 1'b0;
        #1 check("rarb_ra", a_ra, 1); check("rarb_rb", a_rb, 1); check("rarb_stall", a_stall, 1);
        #1 rst_i = 1'b1;
        #1 check("midrst_stall", a_stall, 0); check("midrst_mask", a_mask, 0);
        check("midrst_cnt", a_cnt, 0);
        @(negedge clk_i); rst_i = 1'b0; idle();
        @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
